ecc_sed_enc_arbiter: RTL and testbench

Shares one single-error-detect (even parity) encode path between NUM_REQ requesters using round-robin arbitration. Each requester presents data words with a valid/ready handshake. The winning word is encoded as {^data, data} and captured in a one-entry output register with its source ID. The block sits between the producer clients and the downstream memory/link write port. A saturating counter records completed output transfers.

---
 rtl/ecc_sed_pkg.sv | 21 ++
 rtl/ecc_sed_enc_arbiter_if.sv | 26 ++
 rtl/ecc_rr_arbiter.sv | 35 +++
 rtl/ecc_sed_enc_arbiter.sv | 87 ++++++++
 tb/tb_ecc_sed_enc_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_sed_pkg.sv
// Shared types and the single-error-detect encode used by the arbitrated
// encode path: codeword = {even parity, data}.
package ecc_sed_pkg;

  localparam int DATA_WIDTH     = 12;
  localparam int CODEWORD_WIDTH = DATA_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [CODEWORD_WIDTH-1:0] codeword_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Parity bit makes the XOR of the whole codeword zero.
  function automatic codeword_t sed_encode(input data_t data);
    return {^data, data};
  endfunction

endpackage

// File: rtl/ecc_sed_enc_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for the shared encoder.
interface ecc_sed_enc_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) ();
  import ecc_sed_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               out_valid;
  logic                               out_ready;
  codeword_t                          out_codeword;
  logic [ID_WIDTH-1:0]                out_src_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_codeword, out_src_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_codeword, out_src_id
  );

endinterface

// File: rtl/ecc_rr_arbiter.sv
// Round-robin picker: searches from last_grant+1 upward with wrap; the
// one-hot grant is only driven while advance is high.
module ecc_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic                found;
  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (advance && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/ecc_sed_enc_arbiter.sv
// NUM_REQ requesters share one parity encoder feeding a one-entry output
// register; also counts completed output transfers (saturating).
module ecc_sed_enc_arbiter
  import ecc_sed_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] xfer_count,
  ecc_sed_enc_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ID_WIDTH-1:0]  LAST_RST = ID_WIDTH'(NUM_REQ - 1);

  out_state_e           state_q, state_d;
  codeword_t            cw_q;
  logic [ID_WIDTH-1:0]  src_q;
  logic [ID_WIDTH-1:0]  last_grant_q;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 can_load;
  logic                 accept;
  logic                 out_xfer;

  assign can_load = (state_q == EMPTY) || bus.out_ready;
  assign out_xfer = (state_q == FULL) && bus.out_ready;

  // rst_n gates advance so no requester sees ready while reset is held.
  ecc_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .advance    (can_load & rst_n),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (bus.out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q         <= '0;
      src_q        <= '0;
      last_grant_q <= LAST_RST;
    end else if (accept) begin
      cw_q         <= sed_encode(bus.req_data[grant_idx]);
      src_q        <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

  // Clear wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (cnt_clr)                    cnt_q <= '0;
    else if (out_xfer && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.out_valid    = (state_q == FULL);
  assign bus.out_codeword = cw_q;
  assign bus.out_src_id   = src_q;
  assign xfer_count       = cnt_q;

endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Directed + random bench; a reference model pushes expected codewords on
// accept and a separate monitor pops them on each output handshake.
module tb_ecc_sed_enc_arbiter;
  import ecc_sed_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ID_WIDTH  = 2;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cnt_clr = 1'b0;
  logic [CNT_WIDTH-1:0] xfer_count;

  ecc_sed_enc_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) bus ();

  ecc_sed_enc_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ID_WIDTH  (ID_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr    (cnt_clr),
    .xfer_count (xfer_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    codeword_t           cw;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic codeword_t ref_enc(input logic [DATA_WIDTH-1:0] d);
    return {^d, d};
  endfunction

  // Reference model: expected req_ready, output occupancy and counter.
  logic                 m_full = 1'b0;
  logic [ID_WIDTH-1:0]  m_last = 2'd3;
  logic [CNT_WIDTH-1:0] m_cnt  = '0;
  int                   waitc[NUM_REQ];

  always @(negedge clk) begin
    logic [NUM_REQ-1:0]  exp_rdy;
    logic [ID_WIDTH-1:0] g, c;
    bit                  found;
    if (!rst_n) begin
      m_full = 1'b0;
      m_last = 2'd3;
      m_cnt  = '0;
      sb.delete();
      for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
      chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_full));
      chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
      chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'h1);
      found = 1'b0;
      g     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = ID_WIDTH'(int'(m_last) + k);
        if (!found && bus.req_valid[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
      exp_rdy = (found && (!m_full || bus.out_ready)) ? (NUM_REQ'(1) << g) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (cnt_clr) m_cnt = '0;
      else if (m_full && bus.out_ready && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i]) waitc[i] = 0;
      if (exp_rdy != '0) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == int'(g)) waitc[i] = 0;
          else if (bus.req_valid[i]) begin
            waitc[i]++;
            chk("starvation", 32'(waitc[i] <= NUM_REQ), 32'h1);
          end
        end
        sb.push_back('{g, ref_enc(bus.req_data[g])});
        m_full = 1'b1;
        m_last = g;
      end else if (m_full && bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: every output handshake retires the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      chk("parity", 32'(^bus.out_codeword), 32'h0);
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got codeword %0h expected none at %0t", bus.out_codeword, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_codeword", 32'(bus.out_codeword), 32'(e.cw));
          chk("sb_src_id", 32'(bus.out_src_id), 32'(e.id));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  codeword_t tab[NUM_REQ];

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    // Reset state, requesters valid but reset held.
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_codeword", 32'(bus.out_codeword), 32'h0);
    chk("rst_src_id", 32'(bus.out_src_id), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single word from requester 0.
    step();
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 12'h001;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_codeword", 32'(bus.out_codeword), 32'h1001);
    chk("t1_src", 32'(bus.out_src_id), 32'h0);
    bus.req_valid = '0;
    step();
    chk("t1_count", 32'(xfer_count), 32'h1);
    chk("t1_empty", 32'(bus.out_valid), 32'h0);

    // Requester 3 alone, so the next round starts at 0.
    bus.req_valid   = 4'b1000;
    bus.req_data[3] = 12'h800;
    step();
    bus.req_valid = '0;
    chk("prime_codeword", 32'(bus.out_codeword), 32'h1800);
    chk("prime_src", 32'(bus.out_src_id), 32'h3);
    step();

    // All four valid: strict rotation at full throughput.
    bus.req_data[0] = 12'h000;
    bus.req_data[1] = 12'hFFF;
    bus.req_data[2] = 12'h555;
    bus.req_data[3] = 12'hC3A;
    tab[0] = 13'h0000;
    tab[1] = 13'h0FFF;
    tab[2] = 13'h0555;
    tab[3] = 13'h0C3A; // 0xC3A has six ones, so parity is 0
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_src", 32'(bus.out_src_id), 32'(i % NUM_REQ));
      chk("t2_codeword", 32'(bus.out_codeword), 32'(tab[i % NUM_REQ]));
    end
    bus.req_valid = '0;
    step();
    chk("t2_count", 32'(xfer_count), 32'd10);

    // Backpressure: hold for 5 cycles, then 1 and 2 drain back-to-back.
    bus.out_ready   = 1'b0;
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 12'h124;
    step();
    bus.req_valid   = 4'b0110;
    bus.req_data[1] = 12'h0AA;
    bus.req_data[2] = 12'h0F0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_ready", 32'(bus.req_ready), 32'h0);
      chk("t3_hold_codeword", 32'(bus.out_codeword), 32'h1124);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_ready1", 32'(bus.req_ready), 32'h2);
    step();
    chk("t3_codeword1", 32'(bus.out_codeword), 32'h00AA);
    chk("t3_src1", 32'(bus.out_src_id), 32'h1);
    #1;
    chk("t3_ready2", 32'(bus.req_ready), 32'h4);
    step();
    chk("t3_codeword2", 32'(bus.out_codeword), 32'h00F0);
    chk("t3_src2", 32'(bus.out_src_id), 32'h2);
    bus.req_valid = '0;
    step();
    chk("t3_count", 32'(xfer_count), 32'd13);

    // Counter saturation from a preloaded value, then clear vs. transfer.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 12'h003;
    step();
    step();
    step();
    bus.req_valid = '0;
    step();
    chk("t4_saturate", 32'(xfer_count), 32'hFFFF);
    step();
    chk("t4_stay", 32'(xfer_count), 32'hFFFF);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t4_clear", 32'(xfer_count), 32'h0);

    // Asynchronous reset while streaming.
    bus.req_valid = 4'b1111;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", 32'(bus.out_valid), 32'h0);
    chk("t5_count", 32'(xfer_count), 32'h0);
    chk("t5_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_first_ready", 32'(bus.req_ready), 32'h1);
    step();
    chk("t5_first_src", 32'(bus.out_src_id), 32'h0);
    bus.req_valid = '0;
    step();

    // Random traffic, checked by the model and monitor.
    for (int n = 0; n < 500; n++) begin
      step();
      bus.req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[i] = DATA_WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr       = ($urandom_range(0, 63) == 0);
    end
    step();
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    cnt_clr       = 1'b0;
    step();
    step();
    step();
    chk("drain_sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
